// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong FIFO write arbiter: FSM state
// encoding, FIFO size width and the round-robin pointer update.
package ppfifo_pkg;

    localparam int NUM_REQ     = 2;
    localparam int FIFO_SIZE_W = 24;

    typedef logic [FIFO_SIZE_W-1:0] fifo_size_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // After a buffer is released the preferred requester becomes the one
    // that did not just win (grant 01 -> prefer 1, grant 10 -> prefer 0).
    function automatic logic rr_next_ptr(input logic [NUM_REQ-1:0] grant);
        return grant[0] & ~grant[1];
    endfunction

endpackage

// File: rtl/ppfifo_wr_arbiter_if.sv
// Bundle of requester, downstream ping-pong FIFO and status signals for
// ppfifo_wr_arbiter. The slave modport is the arbiter's view; the master
// modport is the surrounding logic (requesters plus downstream FIFO).
interface ppfifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32
) ();
    import ppfifo_pkg::*;

    // requester 0
    logic                  i_req0_valid;
    logic [1:0]            o_req0_rdy;
    logic [1:0]            i_req0_act;
    fifo_size_t            o_req0_size;
    logic                  i_req0_stb;
    logic [DATA_WIDTH:0]   i_req0_data;
    // requester 1
    logic                  i_req1_valid;
    logic [1:0]            o_req1_rdy;
    logic [1:0]            i_req1_act;
    fifo_size_t            o_req1_size;
    logic                  i_req1_stb;
    logic [DATA_WIDTH:0]   i_req1_data;
    // downstream ping-pong FIFO
    logic [1:0]            i_ppfifo_rdy;
    logic [1:0]            o_ppfifo_act;
    fifo_size_t            i_ppfifo_size;
    logic                  o_ppfifo_stb;
    logic [DATA_WIDTH:0]   o_ppfifo_data;
    // status
    logic [1:0]            o_grant;
    logic                  o_overflow;

    modport slave (
        input  i_req0_valid, i_req0_act, i_req0_stb, i_req0_data,
        input  i_req1_valid, i_req1_act, i_req1_stb, i_req1_data,
        input  i_ppfifo_rdy, i_ppfifo_size,
        output o_req0_rdy, o_req0_size, o_req1_rdy, o_req1_size,
        output o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data,
        output o_grant, o_overflow
    );

    modport master (
        output i_req0_valid, i_req0_act, i_req0_stb, i_req0_data,
        output i_req1_valid, i_req1_act, i_req1_stb, i_req1_data,
        output i_ppfifo_rdy, i_ppfifo_size,
        input  o_req0_rdy, o_req0_size, o_req1_rdy, o_req1_size,
        input  o_ppfifo_act, o_ppfifo_stb, o_ppfifo_data,
        input  o_grant, o_overflow
    );

endinterface

// File: rtl/ppfifo_rr_select.sv
// Two-way round-robin pick: a lone valid requester always wins; when both
// are valid the pointer decides.
module ppfifo_rr_select
    import ppfifo_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               pointer,
    output logic [NUM_REQ-1:0] grant
);

    // Contention resolved purely by the pointer, otherwise pass valid through.
    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = pointer ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ppfifo_wr_arbiter.sv
// Two-requester write arbiter in front of a ping-pong FIFO. A requester is
// granted one downstream buffer, activates it, streams words (forwarded one
// cycle late), then releases it. Words beyond the buffer size are dropped
// and flagged on a sticky overflow bit.
// Optional feature: define PPFIFO_WR_ARBITER_TIMEOUT_EN to release a grant
// whose requester fails to activate within GRANT_TIMEOUT cycles.
module ppfifo_wr_arbiter
    import ppfifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int GRANT_TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    ppfifo_wr_arbiter_if.slave bus
);

    localparam int TMR_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GRANT_TIMEOUT - 1);
`ifdef PPFIFO_WR_ARBITER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    arb_state_t          state_reg;
    logic [1:0]          act_reg;
    logic [1:0]          grant_reg;
    logic                rdy_reg;
    logic                ptr_reg;
    fifo_size_t          count_reg;
    logic                stb_reg;
    logic [DATA_WIDTH:0] data_reg;
    logic                overflow_reg;
    logic [TMR_W-1:0]    timer_reg;

    // Requester inputs gathered into arrays so the winner can be indexed.
    logic [NUM_REQ-1:0]  valid_vec;
    logic [NUM_REQ-1:0]  stb_vec;
    logic [1:0]          act_vec  [NUM_REQ];
    logic [DATA_WIDTH:0] data_vec [NUM_REQ];
    logic [1:0]          rdy_vec  [NUM_REQ];
    fifo_size_t          size_vec [NUM_REQ];

    assign valid_vec   = {bus.i_req1_valid, bus.i_req0_valid};
    assign stb_vec     = {bus.i_req1_stb, bus.i_req0_stb};
    assign act_vec[0]  = bus.i_req0_act;
    assign act_vec[1]  = bus.i_req1_act;
    assign data_vec[0] = bus.i_req0_data;
    assign data_vec[1] = bus.i_req1_data;

    // Only the granted requester sees ready and the buffer size.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign rdy_vec[gi]  = {1'b0, rdy_reg & grant_reg[gi]};
        assign size_vec[gi] = grant_reg[gi] ? bus.i_ppfifo_size : '0;
    end

    assign bus.o_req0_rdy  = rdy_vec[0];
    assign bus.o_req1_rdy  = rdy_vec[1];
    assign bus.o_req0_size = size_vec[0];
    assign bus.o_req1_size = size_vec[1];

    assign bus.o_ppfifo_act  = act_reg;
    assign bus.o_ppfifo_stb  = stb_reg;
    assign bus.o_ppfifo_data = data_reg;
    assign bus.o_grant       = grant_reg;
    assign bus.o_overflow    = overflow_reg;

    logic [NUM_REQ-1:0]  sel_grant;
    logic                win_idx;
    logic [1:0]          win_act;
    logic                win_stb;
    logic [DATA_WIDTH:0] win_data;

    ppfifo_rr_select u_rr_select (
        .valid   (valid_vec),
        .pointer (ptr_reg),
        .grant   (sel_grant)
    );

    assign win_idx  = grant_reg[1];
    assign win_act  = act_vec[win_idx];
    assign win_stb  = stb_vec[win_idx];
    assign win_data = data_vec[win_idx];

    // Arbitration FSM with all downstream and requester-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            act_reg      <= 2'b00;
            grant_reg    <= 2'b00;
            rdy_reg      <= 1'b0;
            ptr_reg      <= 1'b0;
            count_reg    <= '0;
            stb_reg      <= 1'b0;
            data_reg     <= '0;
            overflow_reg <= 1'b0;
            timer_reg    <= '0;
        end else begin
            stb_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if ((act_reg == 2'b00) && (bus.i_ppfifo_rdy != 2'b00) && (|valid_vec)) begin
                        act_reg   <= bus.i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                        grant_reg <= sel_grant;
                        count_reg <= '0;
                        timer_reg <= '0;
                        rdy_reg   <= 1'b1;
                        state_reg <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (win_act != 2'b00) begin
                        rdy_reg   <= 1'b0;
                        state_reg <= ST_ACTIVE;
                    end else if (TIMEOUT_EN && (timer_reg == TMR_LAST)) begin
                        // Requester never activated: hand the buffer back empty.
                        rdy_reg   <= 1'b0;
                        state_reg <= ST_RELEASE;
                    end else if (TIMEOUT_EN) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (win_stb) begin
                        if (count_reg == bus.i_ppfifo_size) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            stb_reg   <= 1'b1;
                            data_reg  <= win_data;
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                    // A strobe coincident with deactivation is still taken above.
                    if (win_act == 2'b00) begin
                        state_reg <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    act_reg   <= 2'b00;
                    grant_reg <= 2'b00;
                    ptr_reg   <= rr_next_ptr(grant_reg);
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppfifo_wr_arbiter.sv
// Self-checking bench for ppfifo_wr_arbiter. A transaction-level model
// predicts the winner of each buffer (round-robin by last winner), the
// forwarded word stream (first min(n, size) words, each one cycle after its
// strobe) and the sticky overflow flag. Payloads are random.
// Defining PPFIFO_WR_ARBITER_TIMEOUT_EN adds the grant-timeout scenario.
module tb_ppfifo_wr_arbiter;

`ifdef PPFIFO_WR_ARBITER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 256;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ppfifo_wr_arbiter_if #(.DATA_WIDTH(32)) bus ();

    ppfifo_wr_arbiter #(
        .DATA_WIDTH    (32),
        .GRANT_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model state
    int          model_ptr = 0;
    bit          model_ovf = 1'b0;
    int          exp_cyc[$];
    logic [32:0] exp_dat[$];
    int          got_cyc[$];
    logic [32:0] got_dat[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture every forwarded word mid-cycle, with the cycle it appeared in.
    always @(negedge clk) begin
        if (bus.o_ppfifo_stb === 1'b1) begin
            got_cyc.push_back(cyc);
            got_dat.push_back(bus.o_ppfifo_data);
            check("stb_outside_act", 64'(bus.o_ppfifo_act != 2'b00), 64'd1);
        end
    end

    task automatic drive_req(input int who, input logic [1:0] act, input logic stb, input logic [32:0] d);
        if (who == 0) begin
            bus.i_req0_act = act; bus.i_req0_stb = stb; bus.i_req0_data = d;
        end else begin
            bus.i_req1_act = act; bus.i_req1_stb = stb; bus.i_req1_data = d;
        end
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_nwords"}, 64'(got_dat.size()), 64'(exp_dat.size()));
        for (int i = 0; i < got_dat.size() && i < exp_dat.size(); i++) begin
            check({tag, "_word"}, 64'(got_dat[i]), 64'(exp_dat[i]));
            check({tag, "_word_cycle"}, 64'(got_cyc[i]), 64'(exp_cyc[i]));
        end
        got_dat.delete(); got_cyc.delete(); exp_dat.delete(); exp_cyc.delete();
    endtask

    // One complete buffer: wait for grant, activate, stream nwords, release.
    task automatic run_buffer(input bit v0, input bit v1, input int nwords, input logic [23:0] size,
                              input logic [1:0] prdy, input bit drop_with_last, input bit hold_valid);
        int          who;
        int          waited;
        logic [1:0]  act_val;
        logic [32:0] w;
        bus.i_ppfifo_rdy  = prdy;
        bus.i_ppfifo_size = size;
        bus.i_req0_valid  = v0;
        bus.i_req1_valid  = v1;
        who     = (v0 && v1) ? model_ptr : (v0 ? 0 : 1);
        act_val = prdy[0] ? 2'b01 : 2'b10;
        waited  = 0;
        while (bus.o_req0_rdy !== 2'b01 && bus.o_req1_rdy !== 2'b01 && waited < 20) begin
            tick();
            waited++;
        end
        check("grant_wait_expired", 64'(waited < 20), 64'd1);
        if (waited >= 20) return;
        check("grant", 64'(bus.o_grant), (who == 0) ? 64'd1 : 64'd2);
        check("ppfifo_act", 64'(bus.o_ppfifo_act), 64'(act_val));
        check("winner_rdy", 64'((who == 0) ? bus.o_req0_rdy : bus.o_req1_rdy), 64'd1);
        check("loser_rdy", 64'((who == 0) ? bus.o_req1_rdy : bus.o_req0_rdy), 64'd0);
        check("winner_size", 64'((who == 0) ? bus.o_req0_size : bus.o_req1_size), 64'(size));
        check("loser_size", 64'((who == 0) ? bus.o_req1_size : bus.o_req0_size), 64'd0);
        drive_req(who, act_val, 1'b0, '0);
        tick();
        check("rdy_after_act", 64'((who == 0) ? bus.o_req0_rdy : bus.o_req1_rdy), 64'd0);
        for (int i = 0; i < nwords; i++) begin
            w = {(i == nwords - 1) ? 1'b1 : 1'b0, 32'($urandom)};
            drive_req(who, (drop_with_last && i == nwords - 1) ? 2'b00 : act_val, 1'b1, w);
            if (i < int'(size)) begin
                exp_dat.push_back(w);
                exp_cyc.push_back(cyc + 1);
            end
            tick();
        end
        if (nwords > int'(size)) model_ovf = 1'b1;
        drive_req(who, 2'b00, 1'b0, '0);
        waited = 0;
        while (bus.o_ppfifo_act !== 2'b00 && waited < 10) begin
            tick();
            waited++;
        end
        check("released_act", 64'(bus.o_ppfifo_act), 64'd0);
        check("released_grant", 64'(bus.o_grant), 64'd0);
        if (!hold_valid) begin
            bus.i_req0_valid = 1'b0;
            bus.i_req1_valid = 1'b0;
        end
        model_ptr = 1 - who;
        compare_stream("stream");
        check("overflow", 64'(bus.o_overflow), 64'(model_ovf));
    endtask

    initial begin
        bus.i_req0_valid = 1'b0; bus.i_req0_act = 2'b00; bus.i_req0_stb = 1'b0; bus.i_req0_data = '0;
        bus.i_req1_valid = 1'b0; bus.i_req1_act = 2'b00; bus.i_req1_stb = 1'b0; bus.i_req1_data = '0;
        bus.i_ppfifo_rdy = 2'b00; bus.i_ppfifo_size = '0;

        // Reset state
        repeat (3) tick();
        check("rst_act", 64'(bus.o_ppfifo_act), 64'd0);
        check("rst_stb", 64'(bus.o_ppfifo_stb), 64'd0);
        check("rst_data", 64'(bus.o_ppfifo_data), 64'd0);
        check("rst_grant", 64'(bus.o_grant), 64'd0);
        check("rst_ovf", 64'(bus.o_overflow), 64'd0);
        check("rst_rdy0", 64'(bus.o_req0_rdy), 64'd0);
        check("rst_rdy1", 64'(bus.o_req1_rdy), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single requester, 4 words into a size-4 buffer
        run_buffer(1'b1, 1'b0, 4, 24'd4, 2'b01, 1'b0, 1'b0);

        // Overrun: 3 words into size 2, then the flag must persist
        run_buffer(1'b0, 1'b1, 3, 24'd2, 2'b01, 1'b0, 1'b0);
        run_buffer(1'b1, 1'b0, 1, 24'd4, 2'b01, 1'b0, 1'b0);

        // Reset mid-ACTIVE after 3 of 8 words
        bus.i_ppfifo_rdy = 2'b01; bus.i_ppfifo_size = 24'd8; bus.i_req0_valid = 1'b1;
        for (int i = 0; i < 20 && bus.o_req0_rdy !== 2'b01; i++) tick();
        check("rst_test_grant", 64'(bus.o_req0_rdy), 64'd1);
        drive_req(0, 2'b01, 1'b0, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_req(0, 2'b01, 1'b1, 33'($urandom));
            tick();
        end
        check("stb_before_rst", 64'(bus.o_ppfifo_stb), 64'd1);
        #2 rst_n = 1'b0;
        bus.i_req0_valid = 1'b0;
        #1;
        check("async_rst_act", 64'(bus.o_ppfifo_act), 64'd0);
        check("async_rst_stb", 64'(bus.o_ppfifo_stb), 64'd0);
        check("async_rst_grant", 64'(bus.o_grant), 64'd0);
        check("async_rst_ovf", 64'(bus.o_overflow), 64'd0);
        got_dat.delete(); got_cyc.delete(); exp_dat.delete(); exp_cyc.delete();
        model_ptr = 0;
        model_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(0, 2'b01, 1'b1, 33'($urandom));
            tick();
        end
        drive_req(0, 2'b00, 1'b0, '0);
        tick();
        check("no_stb_after_rst", 64'(got_dat.size()), 64'd0);
        check("idle_act_after_rst", 64'(bus.o_ppfifo_act), 64'd0);

        // Contention: both valid throughout, four buffers -> 0,1,0,1
        for (int b = 0; b < 4; b++) begin
            run_buffer(1'b1, 1'b1, int'($urandom_range(1, 4)), 24'd4, 2'b01, 1'b0, (b != 3));
        end

        // Downstream only offers buffer 1; last strobe coincides with act drop
        run_buffer(1'b0, 1'b1, 3, 24'd5, 2'b10, 1'b1, 1'b0);

`ifdef PPFIFO_WR_ARBITER_TIMEOUT_EN
        // Winner never activates: released after TB_TIMEOUT grant cycles
        begin
            int gcycles;
            bus.i_ppfifo_rdy = 2'b01; bus.i_ppfifo_size = 24'd4;
            bus.i_req0_valid = 1'b1; bus.i_req1_valid = 1'b1;
            for (int i = 0; i < 20 && bus.o_req0_rdy !== 2'b01; i++) tick();
            check("to_first_grant", 64'(bus.o_grant), (model_ptr == 0) ? 64'd1 : 64'd2);
            gcycles = 0;
            while ((bus.o_req0_rdy === 2'b01 || bus.o_req1_rdy === 2'b01) && gcycles < 40) begin
                gcycles++;
                tick();
            end
            check("to_grant_cycles", 64'(gcycles), 64'(TB_TIMEOUT));
            model_ptr = 1 - model_ptr;
            run_buffer(1'b1, 1'b1, 2, 24'd4, 2'b01, 1'b0, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
